// File: rtl/ads131_pkg.sv
// ads131_pkg
// Shared constants and types for the ADS131A0X command sequencer:
//   - fixed command words (NULL, WAKEUP, LOCK, UNLOCK)
//   - WREG echo opcode/mask (the ADC answers WREG 0b010x with 0b001x)
//   - sequencer state, frame phase and error code enums
package ads131_pkg;

    localparam logic [15:0] CMD_NULL   = 16'h0000;
    localparam logic [15:0] CMD_WAKEUP = 16'h0033;
    localparam logic [15:0] CMD_LOCK   = 16'h0555;
    localparam logic [15:0] CMD_UNLOCK = 16'h0655;

    localparam logic [15:0] WREG_ECHO_OP   = 16'h2000;
    localparam logic [15:0] WREG_ECHO_MASK = 16'h1FFF;

    localparam logic [15:0] CFG0_DEFAULT = 16'h4B68;  // A_SYS_CFG
    localparam logic [15:0] CFG1_DEFAULT = 16'h4C3C;  // D_SYS_CFG
    localparam logic [15:0] CFG2_DEFAULT = 16'h4F0F;  // ADC_ENA

    typedef enum logic [3:0] {
        ST_RST_PULSE = 4'd0,
        ST_RST_WAIT  = 4'd1,
        ST_POLL      = 4'd2,
        ST_UNLOCK    = 4'd3,
        ST_WREG      = 4'd4,
        ST_WAKEUP    = 4'd5,
        ST_LOCK      = 4'd6,
        ST_STREAM    = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

    // Sub-step of a frame-driven state. CMD sends the command word, CHK sends
    // NULL and reads back the answer to CMD. CMD_GAP sits between the two,
    // GAP follows a completed step. IDLE is only used while streaming.
    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_CMD     = 3'd1,
        PH_CMD_GAP = 3'd2,
        PH_CHK     = 3'd3,
        PH_GAP     = 3'd4
    } phase_t;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_READY  = 3'd1,
        ERR_UNLOCK = 3'd2,
        ERR_WREG   = 3'd3,
        ERR_WAKEUP = 3'd4,
        ERR_LOCK   = 3'd5
    } err_t;

    function automatic logic [15:0] wreg_echo(input logic [15:0] cmd);
        return WREG_ECHO_OP | (cmd & WREG_ECHO_MASK);
    endfunction

endpackage

// File: rtl/ads131_drdy_sync.sv
// ads131_drdy_sync
// Two-flop synchronizer for the asynchronous ADC DRDY line plus a
// falling-edge detector producing a one-clock pulse.
// Ports:
//   synthesized_clock_4_167Mhz  in   block clock
//   reset_n                     in   asynchronous active-low reset
//   drdy_n                      in   raw DRDY, active-low, asynchronous
//   fall                        out  one-cycle pulse on a synchronized fall
module ads131_drdy_sync (
    input  logic synthesized_clock_4_167Mhz,
    input  logic reset_n,
    input  logic drdy_n,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    // Reset to the idle (high) level so release of reset never looks like an edge.
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], drdy_n};
            prev <= sync[1];
        end
    end

    assign fall = prev & ~sync[1];

endmodule

// File: rtl/ads131_init_sequencer.sv
// ads131_init_sequencer
// Boots and configures an ADS131A0X through a 32-bit SPI frame engine, then
// issues one NULL frame per DRDY falling edge and forwards the sample word.
// Ports:
//   synthesized_clock_4_167Mhz  in   block clock
//   reset_n                     in   asynchronous active-low reset
//   frame_req/frame_tx          out  frame request and MOSI word
//   frame_done/frame_rx         in   frame completion pulse and MISO word
//   adc_drdy_n                  in   ADC DRDY (async, active-low)
//   adc_reset_n                 out  ADC hardware reset
//   init_done/init_error        out  streaming active / sticky failure
//   error_code                  out  failing step (see err_t)
//   sample_data/sample_valid    out  last stream word and its 1-cycle strobe
//   sample_overrun              out  sticky: DRDY fell while a frame was busy
//   state_dbg                   out  current state encoding
//
// Handshake: frame_req rises with frame_tx already stable and stays high
// (frame_tx held) until the cycle frame_done is seen; it drops the next clock.
// GAP_CYCLES idle clocks follow every done. frame_done with req low is ignored.
// GAP_CYCLES must be at least 1.
module ads131_init_sequencer
    import ads131_pkg::*;
#(
    parameter int          RESET_CYCLES = 20,
    parameter int          BOOT_WAIT    = 4096,
    parameter int          GAP_CYCLES   = 1,
    parameter int          READY_POLLS  = 255,
    parameter logic [15:0] READY_WORD   = 16'hFF04,
    parameter int          MAX_RETRY    = 3,
    parameter logic [15:0] CFG0         = CFG0_DEFAULT,
    parameter logic [15:0] CFG1         = CFG1_DEFAULT,
    parameter logic [15:0] CFG2         = CFG2_DEFAULT
) (
    input  logic        synthesized_clock_4_167Mhz,
    input  logic        reset_n,
    output logic        frame_req,
    output logic [31:0] frame_tx,
    input  logic        frame_done,
    input  logic [31:0] frame_rx,
    input  logic        adc_drdy_n,
    output logic        adc_reset_n,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  error_code,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    output logic        sample_overrun,
    output logic [3:0]  state_dbg
);

    localparam int WAIT_MAX = (BOOT_WAIT > RESET_CYCLES) ? BOOT_WAIT : RESET_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int POLL_W   = $clog2(READY_POLLS + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int GAP_W    = $clog2(GAP_CYCLES + 1);

    state_t             state, state_n;
    phase_t             phase, phase_n;
    err_t               err_q, err_n;
    logic [WAIT_W-1:0]  wait_cnt, wait_n;
    logic [POLL_W-1:0]  poll_cnt, poll_n;
    logic [RETRY_W-1:0] retry_cnt, retry_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [1:0]         idx, idx_n;
    logic [31:0]        sdata_n;
    logic               svalid_n, overrun_n;
    logic               drdy_fall_raw, drdy_fall;
    logic [15:0]        cfg_word, cmd_word, echo_word, rx_word;
    logic               frame_state;
    err_t               step_err;

    ads131_drdy_sync u_drdy_sync (
        .synthesized_clock_4_167Mhz (synthesized_clock_4_167Mhz),
        .reset_n                    (reset_n),
        .drdy_n                     (adc_drdy_n),
        .fall                       (drdy_fall_raw)
    );

    assign drdy_fall = drdy_fall_raw & (state == ST_STREAM);
    assign rx_word   = frame_rx[31:16];

    always_comb begin
        cfg_word  = CFG2;
        cmd_word  = CMD_NULL;
        echo_word = CMD_NULL;
        step_err  = ERR_NONE;
        case (idx)
            2'd0:    cfg_word = CFG0;
            2'd1:    cfg_word = CFG1;
            default: cfg_word = CFG2;
        endcase
        case (state)
            ST_UNLOCK: begin cmd_word = CMD_UNLOCK; echo_word = CMD_UNLOCK; step_err = ERR_UNLOCK; end
            ST_WREG:   begin cmd_word = cfg_word; echo_word = wreg_echo(cfg_word); step_err = ERR_WREG; end
            ST_WAKEUP: begin cmd_word = CMD_WAKEUP; echo_word = CMD_WAKEUP; step_err = ERR_WAKEUP; end
            ST_LOCK:   begin cmd_word = CMD_LOCK; echo_word = CMD_LOCK; step_err = ERR_LOCK; end
            default:   ;
        endcase
    end

    // Outputs decode straight from async-reset registers, so reset kills an
    // in-flight request immediately.
    assign frame_state = (state != ST_RST_PULSE) && (state != ST_RST_WAIT) && (state != ST_ERROR);
    assign frame_req   = frame_state && ((phase == PH_CMD) || (phase == PH_CHK));
    assign frame_tx    = (frame_req && phase == PH_CMD) ? {cmd_word, 16'h0000} : 32'h0;
    assign adc_reset_n = (state != ST_RST_PULSE);
    assign init_done   = (state == ST_STREAM);
    assign init_error  = (state == ST_ERROR);
    assign error_code  = err_q;
    assign state_dbg   = state;

    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RST_PULSE;
            phase          <= PH_CMD;
            err_q          <= ERR_NONE;
            wait_cnt       <= '0;
            poll_cnt       <= '0;
            retry_cnt      <= '0;
            gap_cnt        <= '0;
            idx            <= '0;
            sample_data    <= '0;
            sample_valid   <= 1'b0;
            sample_overrun <= 1'b0;
        end else begin
            state          <= state_n;
            phase          <= phase_n;
            err_q          <= err_n;
            wait_cnt       <= wait_n;
            poll_cnt       <= poll_n;
            retry_cnt      <= retry_n;
            gap_cnt        <= gap_n;
            idx            <= idx_n;
            sample_data    <= sdata_n;
            sample_valid   <= svalid_n;
            sample_overrun <= overrun_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        err_n     = err_q;
        wait_n    = wait_cnt;
        poll_n    = poll_cnt;
        retry_n   = retry_cnt;
        gap_n     = gap_cnt;
        idx_n     = idx;
        sdata_n   = sample_data;
        svalid_n  = 1'b0;
        overrun_n = sample_overrun;

        case (state)
            ST_RST_PULSE: begin
                if (wait_cnt == WAIT_W'(RESET_CYCLES - 1)) begin
                    state_n = ST_RST_WAIT;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            ST_RST_WAIT: begin
                if (wait_cnt == WAIT_W'(BOOT_WAIT - 1)) begin
                    state_n = ST_POLL;
                    phase_n = PH_CMD;
                    wait_n  = '0;
                    poll_n  = '0;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERROR: ;
            default: begin
                case (phase)
                    PH_IDLE: if (drdy_fall) phase_n = PH_CMD;
                    PH_CMD: begin
                        if (frame_done) begin
                            if (state == ST_POLL) begin
                                if (rx_word == READY_WORD) begin
                                    state_n = ST_UNLOCK;
                                    retry_n = '0;
                                    phase_n = PH_GAP;
                                end else if (poll_cnt == POLL_W'(READY_POLLS - 1)) begin
                                    state_n = ST_ERROR;
                                    err_n   = ERR_READY;
                                end else begin
                                    poll_n  = poll_cnt + POLL_W'(1);
                                    phase_n = PH_GAP;
                                end
                            end else if (state == ST_STREAM) begin
                                sdata_n  = frame_rx;
                                svalid_n = 1'b1;
                                phase_n  = PH_GAP;
                            end else begin
                                phase_n = PH_CMD_GAP;
                            end
                        end
                    end
                    PH_CMD_GAP, PH_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                            gap_n = '0;
                            if (phase == PH_CMD_GAP)
                                phase_n = PH_CHK;
                            else if (state == ST_STREAM)
                                phase_n = PH_IDLE;
                            else
                                phase_n = PH_CMD;
                        end else begin
                            gap_n = gap_cnt + GAP_W'(1);
                        end
                    end
                    PH_CHK: begin
                        if (frame_done) begin
                            if (rx_word == echo_word) begin
                                retry_n = '0;
                                phase_n = PH_GAP;
                                case (state)
                                    ST_UNLOCK: begin state_n = ST_WREG; idx_n = '0; end
                                    ST_WREG: begin
                                        if (idx == 2'd2) state_n = ST_WAKEUP;
                                        else             idx_n   = idx + 2'd1;
                                    end
                                    ST_WAKEUP: state_n = ST_LOCK;
                                    ST_LOCK:   state_n = ST_STREAM;
                                    default:   ;
                                endcase
                            end else if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                                state_n = ST_ERROR;
                                err_n   = step_err;
                            end else begin
                                // Resend the same command word after the gap.
                                retry_n = retry_cnt + RETRY_W'(1);
                                phase_n = PH_GAP;
                            end
                        end
                    end
                    default: phase_n = PH_GAP;
                endcase
                // Edges arriving while a stream frame or its gap is pending are dropped.
                if (drdy_fall && phase != PH_IDLE) overrun_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ads131_init_sequencer.sv
`timescale 1ns/1ps
module tb_ads131_init_sequencer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_req;
    logic [31:0] frame_tx;
    logic        frame_done;
    logic [31:0] frame_rx;
    logic        adc_drdy_n;
    logic        adc_reset_n;
    logic        init_done;
    logic        init_error;
    logic [2:0]  error_code;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_overrun;
    logic [3:0]  state_dbg;

    initial forever #5 clk = ~clk;

    ads131_init_sequencer dut (
        .synthesized_clock_4_167Mhz (clk),
        .reset_n        (reset_n),
        .frame_req      (frame_req),
        .frame_tx       (frame_tx),
        .frame_done     (frame_done),
        .frame_rx       (frame_rx),
        .adc_drdy_n     (adc_drdy_n),
        .adc_reset_n    (adc_reset_n),
        .init_done      (init_done),
        .init_error     (init_error),
        .error_code     (error_code),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_overrun (sample_overrun),
        .state_dbg      (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- ADC / SPI engine model ----------------
    logic [31:0] tx_log[$];
    logic [31:0] stream_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          ready_at;
    int          poll_count;
    bit          ready_sent;
    logic [15:0] prev_cmd;
    int          bad_left;
    int          model_lat;

    initial begin : adc_model
        logic [31:0] tx;
        logic [15:0] echo;
        frame_done = 1'b0;
        frame_rx   = 32'h0;
        forever begin
            @(negedge clk);
            if (frame_req === 1'b1) begin
                tx = frame_tx;
                tx_log.push_back(tx);
                repeat (model_lat) @(negedge clk);
                if (frame_req === 1'b1) begin
                    if (init_done === 1'b1) begin
                        frame_rx = (stream_q.size() > 0) ? stream_q.pop_front() : 32'h0;
                    end else if (!ready_sent) begin
                        poll_count++;
                        if (ready_at > 0 && poll_count == ready_at) begin
                            frame_rx   = 32'hFF04_0000;
                            ready_sent = 1'b1;
                        end else begin
                            frame_rx = 32'h0;
                        end
                    end else begin
                        echo = (prev_cmd[15:13] == 3'b010) ? {3'b001, prev_cmd[12:0]} : prev_cmd;
                        if (prev_cmd == 16'h4C3C && bad_left > 0) begin
                            echo = 16'h2C00;
                            bad_left--;
                        end
                        frame_rx = {echo, 16'h0000};
                    end
                    prev_cmd   = tx[31:16];
                    frame_done = 1'b1;
                    @(negedge clk);
                    frame_done = 1'b0;
                end
            end
        end
    end

    initial begin : sample_monitor
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) got_q.push_back(sample_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_model(input int r_at, input int bad_n, input int lat);
        tx_log.delete();
        stream_q.delete();
        got_q.delete();
        poll_count = 0;
        ready_sent = 1'b0;
        prev_cmd   = 16'h0;
        ready_at   = r_at;
        bad_left   = bad_n;
        model_lat  = lat;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        adc_drdy_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_settled(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (init_done === 1'b1 || init_error === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_init_seq(input int polls, input int cfg1_tries);
        exp_q.delete();
        for (int i = 0; i < polls; i++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0655_0000); exp_q.push_back(32'h0);
        exp_q.push_back(32'h4B68_0000); exp_q.push_back(32'h0);
        for (int i = 0; i < cfg1_tries; i++) begin
            exp_q.push_back(32'h4C3C_0000); exp_q.push_back(32'h0);
        end
    endtask

    task automatic load_tail_seq();
        exp_q.push_back(32'h4F0F_0000); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0033_0000); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0555_0000); exp_q.push_back(32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n    = 1'b0;
        adc_drdy_n = 1'b1;
        set_model(0, 0, 3);
        repeat (3) @(negedge clk);
        total++; if (frame_req !== 1'b0) begin bad++; $display("FAIL reset_frame_req: got %b want 0", frame_req); end
        total++; if (frame_tx !== 32'h0) begin bad++; $display("FAIL reset_frame_tx: got %h want 0", frame_tx); end
        total++; if (adc_reset_n !== 1'b0) begin bad++; $display("FAIL reset_adc_reset_n: got %b want 0", adc_reset_n); end
        total++; if ({init_done, init_error, error_code} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 0", {init_done, init_error, error_code}); end
        total++; if ({sample_data, sample_valid, sample_overrun} !== 34'h0) begin bad++; $display("FAIL reset_sample: got %h want 0", {sample_data, sample_valid, sample_overrun}); end
        total++; if (state_dbg !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_nominal();
        int lo;
        bit ok;
        apply_reset();
        set_model(3, 0, 3);
        reset_n = 1'b1;
        lo = 0;
        while (adc_reset_n === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        total++; if (lo != 20) begin bad++; $display("FAIL nominal_reset_len: got %0d want 20", lo); end
        wait_settled(6000, ok);
        total++; if (!ok) begin bad++; $display("FAIL nominal_timeout: got 0 want 1"); end
        total++; if (init_done !== 1'b1 || init_error !== 1'b0) begin bad++; $display("FAIL nominal_done: got %b%b want 10", init_done, init_error); end
        total++; if (state_dbg !== 4'd7) begin bad++; $display("FAIL nominal_state: got %0d want 7", state_dbg); end
        load_init_seq(3, 1);
        load_tail_seq();
        total++; if (tx_log.size() != exp_q.size()) begin bad++; $display("FAIL nominal_frames: got %0d want %0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= tx_log.size() || tx_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL nominal_tx[%0d]: got %h want %h", i, (i < tx_log.size()) ? tx_log[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_stream();
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h0000_ABCD); exp_q.push_back(32'hFFFF_0001);
        for (int i = 0; i < 3; i++) stream_q.push_back(exp_q[i]);
        for (int k = 0; k < 3; k++) begin
            adc_drdy_n = 1'b0;
            repeat (4) @(negedge clk);
            adc_drdy_n = 1'b1;
            repeat (60) @(negedge clk);
        end
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL stream_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stream_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
            end
        end
        total++; if (sample_overrun !== 1'b0) begin bad++; $display("FAIL stream_overrun: got %b want 0", sample_overrun); end
    endtask

    task automatic test_overrun();
        bit ok;
        got_q.delete();
        model_lat = 10;
        stream_q.push_back(32'hA5A5_0001);
        stream_q.push_back(32'hA5A5_0002);
        adc_drdy_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_req === 1'b1) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL overrun_req: got 0 want 1"); end
        repeat (2) @(negedge clk);
        adc_drdy_n = 1'b1;
        repeat (3) @(negedge clk);
        adc_drdy_n = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (sample_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag: got %b want 1", sample_overrun); end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL overrun_count: got %0d want 1", got_q.size()); end
        adc_drdy_n = 1'b1;
        repeat (30) @(negedge clk);
        adc_drdy_n = 1'b0;
        repeat (4) @(negedge clk);
        adc_drdy_n = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (got_q.size() != 2 || got_q[1] !== 32'hA5A5_0002) begin bad++; $display("FAIL overrun_next: got n=%0d last=%h want n=2 last=a5a50002", got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'hx); end
        total++; if (sample_overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", sample_overrun); end
        model_lat = 3;
    endtask

    task automatic test_reset_mid_wreg();
        bit ok;
        apply_reset();
        set_model(1, 0, 3);
        reset_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (frame_req === 1'b1 && frame_tx === 32'h4B68_0000) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL midreset_reach_wreg: got 0 want 1"); end
        #3 reset_n = 1'b0;
        #1;
        total++; if (frame_req !== 1'b0) begin bad++; $display("FAIL midreset_req: got %b want 0", frame_req); end
        total++; if (adc_reset_n !== 1'b0) begin bad++; $display("FAIL midreset_adc_reset: got %b want 0", adc_reset_n); end
        total++; if (state_dbg !== 4'd0) begin bad++; $display("FAIL midreset_state: got %0d want 0", state_dbg); end
        total++; if (sample_overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun: got %b want 0", sample_overrun); end
        repeat (5) @(negedge clk);
        set_model(1, 0, 3);
        reset_n = 1'b1;
        wait_settled(6000, ok);
        total++; if (!ok || init_done !== 1'b1) begin bad++; $display("FAIL midreset_done: got %b want 1", init_done); end
        load_init_seq(1, 1);
        load_tail_seq();
        total++; if (tx_log.size() != exp_q.size()) begin bad++; $display("FAIL midreset_frames: got %0d want %0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= tx_log.size() || tx_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_tx[%0d]: got %h want %h", i, (i < tx_log.size()) ? tx_log[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_wreg_retry();
        bit ok;
        apply_reset();
        set_model(1, 1, 3);
        reset_n = 1'b1;
        wait_settled(6000, ok);
        total++; if (!ok || init_done !== 1'b1 || error_code !== 3'd0) begin bad++; $display("FAIL retry_done: got %b/%0d want 1/0", init_done, error_code); end
        load_init_seq(1, 2);
        load_tail_seq();
        total++; if (tx_log.size() != exp_q.size()) begin bad++; $display("FAIL retry_frames: got %0d want %0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= tx_log.size() || tx_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL retry_tx[%0d]: got %h want %h", i, (i < tx_log.size()) ? tx_log[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_wreg_fail();
        bit ok;
        apply_reset();
        set_model(1, 4, 3);
        reset_n = 1'b1;
        wait_settled(6000, ok);
        repeat (20) @(negedge clk);
        total++; if (!ok || init_error !== 1'b1 || init_done !== 1'b0) begin bad++; $display("FAIL wregfail_error: got %b%b want 10", init_error, init_done); end
        total++; if (error_code !== 3'd3) begin bad++; $display("FAIL wregfail_code: got %0d want 3", error_code); end
        total++; if (state_dbg !== 4'd8) begin bad++; $display("FAIL wregfail_state: got %0d want 8", state_dbg); end
        total++; if (frame_req !== 1'b0) begin bad++; $display("FAIL wregfail_req: got %b want 0", frame_req); end
        load_init_seq(1, 4);
        total++; if (tx_log.size() != exp_q.size()) begin bad++; $display("FAIL wregfail_frames: got %0d want %0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= tx_log.size() || tx_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL wregfail_tx[%0d]: got %h want %h", i, (i < tx_log.size()) ? tx_log[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_ready_timeout();
        bit ok;
        int nonzero;
        apply_reset();
        set_model(0, 0, 3);
        reset_n = 1'b1;
        wait_settled(12000, ok);
        repeat (30) @(negedge clk);
        total++; if (!ok || init_error !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b want 1", init_error); end
        total++; if (error_code !== 3'd1) begin bad++; $display("FAIL timeout_code: got %0d want 1", error_code); end
        total++; if (frame_req !== 1'b0) begin bad++; $display("FAIL timeout_req: got %b want 0", frame_req); end
        total++; if (tx_log.size() != 255) begin bad++; $display("FAIL timeout_polls: got %0d want 255", tx_log.size()); end
        nonzero = 0;
        foreach (tx_log[i]) if (tx_log[i] !== 32'h0) nonzero++;
        total++; if (nonzero != 0) begin bad++; $display("FAIL timeout_null: got %0d non-NULL frames want 0", nonzero); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_stream();
        test_overrun();
        test_reset_mid_wreg();
        test_wreg_retry();
        test_wreg_fail();
        test_ready_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
